// File: rtl/reg_file_sb.sv
// reg_file_sb: byte-maskable register file with a per-register pending
// scoreboard. All state updates on the falling clock edge; reads, write
// bypass and busy status are combinational.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RegWre,
  input  logic [ADDR_W-1:0]   WriteReg,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic [DATA_W/8-1:0] WrByteEn,
  input  logic [ADDR_W-1:0]   ReadReg1,
  input  logic [ADDR_W-1:0]   ReadReg2,
  output logic [DATA_W-1:0]   ReadData1,
  output logic [DATA_W-1:0]   ReadData2,
  input  logic                IssueWre,
  input  logic [ADDR_W-1:0]   IssueReg,
  output logic                Busy1,
  output logic                Busy2,
  output logic [ADDR_W:0]     PendCount
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [ADDR_W:0]   pend_cnt_q;
  logic [ADDR_W:0]   pend_cnt_d;

  logic              wr_ok;
  logic              is_ok;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_merged;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic [1:0]        rd_busy;

  // Writes/issues are suppressed during reset and for a hardwired zero register.
  assign wr_ok = RegWre   && RST && !(HAS_ZERO && (WriteReg == '0));
  assign is_ok = IssueWre && RST && !(HAS_ZERO && (IssueReg == '0));

  assign wr_old = regs_q[WriteReg];

  genvar gi;

  // Byte-level merge of new data over the current contents of the target.
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_merge
      assign wr_merged[gi*8 +: 8] = WrByteEn[gi] ? WriteData[gi*8 +: 8] : wr_old[gi*8 +: 8];
    end
  endgenerate

  assign rd_addr[0] = ReadReg1;
  assign rd_addr[1] = ReadReg2;

  // Read ports: zero register, then same-cycle write bypass, then storage.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rd_data[gi] = regs_q[rd_addr[gi]];
        if (HAS_ZERO && (rd_addr[gi] == '0)) begin
          rd_data[gi] = '0;
        end else if (wr_ok && (WriteReg == rd_addr[gi])) begin
          rd_data[gi] = wr_merged;
        end
      end
      assign rd_busy[gi] = pend_q[rd_addr[gi]] && !(wr_ok && (WriteReg == rd_addr[gi]));
    end
  endgenerate

  assign ReadData1 = rd_data[0];
  assign ReadData2 = rd_data[1];
  assign Busy1     = rd_busy[0];
  assign Busy2     = rd_busy[1];
  assign PendCount = pend_cnt_q;

  // Register storage: one falling-edge register per entry with async clear.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_regs
      always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
          regs_q[gi] <= '0;
        end else if (wr_ok && (WriteReg == ADDR_W'(gi))) begin
          regs_q[gi] <= wr_merged;
        end
      end
    end
  endgenerate

  // Next pending vector: clear by write first, so a same-edge issue wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok) pend_d[WriteReg] = 1'b0;
    if (is_ok) pend_d[IssueReg] = 1'b1;
  end

  // Count deltas only on real state changes of the targeted bits.
  always_comb begin
    cnt_inc    = is_ok && !pend_q[IssueReg];
    cnt_dec    = wr_ok && pend_q[WriteReg] && !(is_ok && (IssueReg == WriteReg));
    pend_cnt_d = pend_cnt_q;
    if (cnt_inc && !cnt_dec) begin
      pend_cnt_d = pend_cnt_q + 1'b1;
    end else if (cnt_dec && !cnt_inc) begin
      pend_cnt_d = pend_cnt_q - 1'b1;
    end
  end

  // Scoreboard state and its running population count.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb: directed scenarios plus randomized traffic
// checked against an array-based reference model updated on falling edges.
module tb_reg_file_sb;

  logic        CLK;
  logic        RST;
  logic        RegWre;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [3:0]  WrByteEn;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        IssueWre;
  logic [4:0]  IssueReg;
  logic        Busy1;
  logic        Busy2;
  logic [5:0]  PendCount;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [32];
  bit          m_pend [32];

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST(RST), .RegWre(RegWre), .WriteReg(WriteReg),
    .WriteData(WriteData), .WrByteEn(WrByteEn), .ReadReg1(ReadReg1),
    .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .IssueWre(IssueWre), .IssueReg(IssueReg), .Busy1(Busy1), .Busy2(Busy2),
    .PendCount(PendCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic logic [31:0] merge(input logic [31:0] old_v);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++)
      if (WrByteEn[k]) r[k*8 +: 8] = WriteData[k*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (RST && RegWre && WriteReg == a) return merge(m_mem[a]);
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    return m_pend[a] && !(RST && RegWre && WriteReg == a);
  endfunction

  function automatic int exp_cnt();
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'd0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (RST) begin
      if (RegWre && WriteReg != 5'd0) begin
        m_mem[WriteReg]  = merge(m_mem[WriteReg]);
        m_pend[WriteReg] = 1'b0;
      end
      if (IssueWre && IssueReg != 5'd0) m_pend[IssueReg] = 1'b1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic [4:0] r1, input logic [4:0] r2,
                       input logic iw, input logic [4:0] ia);
    @(posedge CLK);
    #1;
    RegWre = we; WriteReg = wa; WriteData = wd; WrByteEn = be;
    ReadReg1 = r1; ReadReg2 = r2; IssueWre = iw; IssueReg = ia;
    #1;
  endtask

  task automatic step();
    @(negedge CLK);
    model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b0;
    model_clear();
    drive(1'b1, 5'd5, 32'hFFFF_FFFF, 4'hF, 5'd5, 5'd9, 1'b1, 5'd9);
    step();
    step();
    checks++;
    if (PendCount !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", PendCount); end
    checks++;
    if (ReadData1 !== 32'd0) begin errors++; $display("FAIL reset_rd1 got %h exp 0", ReadData1); end
    checks++;
    if (Busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2 got %b exp 0", Busy2); end
    drive(1'b0, 5'd0, 32'd0, 4'h0, 5'd5, 5'd9, 1'b0, 5'd0);
    RST = 1'b1;
    step();
    checks++;
    if (ReadData1 !== 32'd0 || PendCount !== 6'd0) begin
      errors++; $display("FAIL reset_release got rd1=%h cnt=%0d exp 0 0", ReadData1, PendCount);
    end
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 4'hF, 5'd5, 5'd0, 1'b0, 5'd0);
    checks++;
    if (ReadData1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_bypass got %h exp deadbeef", ReadData1); end
    step();
    drive(1'b0, 5'd0, 32'd0, 4'h0, 5'd5, 5'd0, 1'b0, 5'd0);
    checks++;
    if (ReadData1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_read got %h exp deadbeef", ReadData1); end
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF, 5'd0, 5'd5, 1'b0, 5'd0);
    checks++;
    if (ReadData1 !== 32'd0) begin errors++; $display("FAIL r0_bypass got %h exp 0", ReadData1); end
    step();
    drive(1'b0, 5'd0, 32'd0, 4'h0, 5'd0, 5'd5, 1'b0, 5'd0);
    checks++;
    if (ReadData1 !== 32'd0) begin errors++; $display("FAIL r0_read got %h exp 0", ReadData1); end
    $display("test_write_read done");
  endtask

  task automatic test_byte_mask();
    drive(1'b1, 5'd5, 32'h1122_3344, 4'b0101, 5'd5, 5'd5, 1'b0, 5'd0);
    checks++;
    if (ReadData1 !== 32'hDE22_BE44) begin errors++; $display("FAIL mask_bypass got %h exp de22be44", ReadData1); end
    step();
    drive(1'b1, 5'd5, 32'h5555_5555, 4'b0000, 5'd5, 5'd0, 1'b0, 5'd0);
    checks++;
    if (ReadData1 !== 32'hDE22_BE44) begin errors++; $display("FAIL mask_stored got %h exp de22be44", ReadData1); end
    step();
    $display("test_byte_mask done");
  endtask

  task automatic test_scoreboard();
    drive(1'b0, 5'd0, 32'd0, 4'h0, 5'd3, 5'd7, 1'b1, 5'd3);
    step();
    drive(1'b0, 5'd0, 32'd0, 4'h0, 5'd3, 5'd7, 1'b1, 5'd7);
    step();
    drive(1'b0, 5'd0, 32'd0, 4'h0, 5'd3, 5'd7, 1'b0, 5'd0);
    checks++;
    if (PendCount !== 6'd2) begin errors++; $display("FAIL sb_cnt2 got %0d exp 2", PendCount); end
    checks++;
    if (Busy1 !== 1'b1 || Busy2 !== 1'b1) begin errors++; $display("FAIL sb_busy got %b%b exp 11", Busy1, Busy2); end
    drive(1'b1, 5'd3, 32'h0000_0033, 4'hF, 5'd3, 5'd7, 1'b0, 5'd0);
    checks++;
    if (Busy1 !== 1'b0) begin errors++; $display("FAIL sb_release got %b exp 0", Busy1); end
    checks++;
    if (PendCount !== 6'd2) begin errors++; $display("FAIL sb_cnt_pre got %0d exp 2", PendCount); end
    step();
    checks++;
    if (PendCount !== 6'd1) begin errors++; $display("FAIL sb_cnt1 got %0d exp 1", PendCount); end
    $display("test_scoreboard done");
  endtask

  task automatic test_issue_write_same();
    drive(1'b0, 5'd0, 32'd0, 4'h0, 5'd9, 5'd0, 1'b1, 5'd9);
    step();
    checks++;
    if (PendCount !== 6'd2) begin errors++; $display("FAIL same_pre got %0d exp 2", PendCount); end
    drive(1'b1, 5'd9, 32'hCAFE_F00D, 4'hF, 5'd9, 5'd0, 1'b1, 5'd9);
    step();
    drive(1'b0, 5'd0, 32'd0, 4'h0, 5'd9, 5'd0, 1'b0, 5'd0);
    checks++;
    if (Busy1 !== 1'b1) begin errors++; $display("FAIL same_busy got %b exp 1", Busy1); end
    checks++;
    if (PendCount !== 6'd2) begin errors++; $display("FAIL same_cnt got %0d exp 2", PendCount); end
    checks++;
    if (ReadData1 !== 32'hCAFE_F00D) begin errors++; $display("FAIL same_data got %h exp cafef00d", ReadData1); end
    $display("test_issue_write_same done");
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 4'($urandom),
            5'($urandom), 5'($urandom), 1'($urandom_range(0, 2) == 0), 5'($urandom));
      checks++;
      if (ReadData1 !== exp_rd(ReadReg1) || ReadData2 !== exp_rd(ReadReg2)) begin
        errors++;
        $display("FAIL rnd_rd c=%0d got %h/%h exp %h/%h", c, ReadData1, ReadData2,
                 exp_rd(ReadReg1), exp_rd(ReadReg2));
      end
      checks++;
      if (Busy1 !== exp_busy(ReadReg1) || Busy2 !== exp_busy(ReadReg2)) begin
        errors++;
        $display("FAIL rnd_busy c=%0d got %b%b exp %b%b", c, Busy1, Busy2,
                 exp_busy(ReadReg1), exp_busy(ReadReg2));
      end
      step();
      checks++;
      if (int'(PendCount) != exp_cnt()) begin
        errors++; $display("FAIL rnd_cnt c=%0d got %0d exp %0d", c, PendCount, exp_cnt());
      end
    end
    $display("test_random done n=%0d", n);
  endtask

  task automatic test_fill();
    for (int r = 1; r < 32; r++) begin
      drive(1'b0, 5'd0, 32'd0, 4'h0, 5'(r), 5'd0, 1'b1, 5'(r));
      step();
    end
    checks++;
    if (PendCount !== 6'd31) begin errors++; $display("FAIL fill_cnt got %0d exp 31", PendCount); end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 5'd0, 32'd0, 4'h0, 5'd0, 5'd0, 1'b1, 5'($urandom_range(1, 31)));
      step();
      checks++;
      if (PendCount !== 6'd31) begin errors++; $display("FAIL fill_reissue got %0d exp 31", PendCount); end
    end
    drive(1'b0, 5'd0, 32'd0, 4'h0, 5'd0, 5'd31, 1'b1, 5'd0);
    step();
    checks++;
    if (PendCount !== 6'd31) begin errors++; $display("FAIL fill_r0 got %0d exp 31", PendCount); end
    checks++;
    if (Busy1 !== 1'b0 || Busy2 !== 1'b1) begin errors++; $display("FAIL fill_busy got %b%b exp 01", Busy1, Busy2); end
    $display("test_fill done");
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd5, 32'h1234_5678, 4'hF, 5'd5, 5'd9, 1'b1, 5'd9);
    #1;
    RST = 1'b0;
    model_clear();
    #1;
    checks++;
    if (PendCount !== 6'd0) begin errors++; $display("FAIL ar_cnt got %0d exp 0", PendCount); end
    checks++;
    if (Busy1 !== 1'b0 || Busy2 !== 1'b0) begin errors++; $display("FAIL ar_busy got %b%b exp 00", Busy1, Busy2); end
    checks++;
    if (ReadData1 !== 32'd0 || ReadData2 !== 32'd0) begin
      errors++; $display("FAIL ar_rd got %h/%h exp 0/0", ReadData1, ReadData2);
    end
    step();
    drive(1'b0, 5'd0, 32'd0, 4'h0, 5'd9, 5'd7, 1'b0, 5'd0);
    RST = 1'b1;
    step();
    checks++;
    if (ReadData1 !== 32'd0 || ReadData2 !== 32'd0 || PendCount !== 6'd0 || Busy1 !== 1'b0) begin
      errors++; $display("FAIL ar_after got %h/%h cnt=%0d b=%b exp 0", ReadData1, ReadData2, PendCount, Busy1);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    RST = 1'b0; RegWre = 1'b0; WriteReg = '0; WriteData = '0; WrByteEn = '0;
    ReadReg1 = '0; ReadReg2 = '0; IssueWre = 1'b0; IssueReg = '0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_scoreboard();
    test_issue_write_same();
    test_random(400);
    test_fill();
    test_async_reset();
    test_random(200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
